// File: rtl/fifo_arb_pkg.sv
// Shared arbiter types and round-robin search helper; purely combinational, no state.
// Backpressure: n/a (definitions only).
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    localparam int unsigned RR_MAX_REQ = 16;

    // First set bit of req at or after ptr, wrapping modulo n; 0 when req is empty.
    function automatic int unsigned rr_next(input int unsigned ptr,
                                            input logic [RR_MAX_REQ-1:0] req,
                                            input int unsigned n);
        int unsigned win;
        win = 0;
        for (int k = RR_MAX_REQ - 1; k >= 0; k--) begin
            if (unsigned'(k) < n) begin
                if (req[4'((ptr + unsigned'(k)) % n)]) begin
                    win = (ptr + unsigned'(k)) % n;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle of the write arbiter; slave = arbiter, master = surroundings.
// Latency/backpressure: n/a (wiring only).
interface fifo_wr_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(N_REQ)
);
    logic [N_REQ-1:0]       req_i;
    logic [N_REQ*WIDTH-1:0] data_i;
    logic [N_REQ-1:0]       gnt_o;
    logic                   fifo_wr_en_o;
    logic [WIDTH-1:0]       fifo_wr_data_o;
    logic                   fifo_full_i;
    logic                   fifo_wr_error_i;
    logic [IDX_W-1:0]       owner_o;
    logic                   busy_o;
    logic                   ovf_err_o;

    modport slave (
        input  req_i, data_i, fifo_full_i, fifo_wr_error_i,
        output gnt_o, fifo_wr_en_o, fifo_wr_data_o, owner_o, busy_o, ovf_err_o
    );

    modport master (
        output req_i, data_i, fifo_full_i, fifo_wr_error_i,
        input  gnt_o, fifo_wr_en_o, fifo_wr_data_o, owner_o, busy_o, ovf_err_o
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin winner finder: 0-cycle latency, no backpressure of its own.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             vld_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [N_REQ-1:0] onehot_o
);

    always_comb begin
        vld_o    = |req_i;
        idx_o    = '0;
        onehot_o = '0;
        if (vld_o) begin
            idx_o           = IDX_W'(rr_next(32'(ptr_i), RR_MAX_REQ'(req_i), N_REQ));
            onehot_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter onto one FIFO write port, 0-cycle req->write; grants withheld while FIFO full.
// FIFO_ARB_BURST_EN compiles in burst lock (owner keeps the port for up to MAX_BURST beats).
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int IDX_W     = $clog2(N_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    fifo_wr_arbiter_if.slave   bus
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic             ovf_q, ovf_d;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] gnt_vis;
    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_onehot;

    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(N_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i    (bus.req_i),
        .ptr_i    (ptr_q),
        .vld_o    (pick_vld),
        .idx_o    (pick_idx),
        .onehot_o (pick_onehot)
    );

`ifdef FIFO_ARB_BURST_EN
    localparam bit LOCK_EN = (MAX_BURST > 1);
    localparam int CNT_W   = $clog2(MAX_BURST + 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        gnt     = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_vld && !bus.fifo_full_i) begin
                    gnt     = pick_onehot;
                    owner_d = pick_idx;
                    if (LOCK_EN) begin
                        state_d = ARB_BURST;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        ptr_d = ptr_inc(pick_idx);
                    end
                end
            end
            ARB_BURST: begin
                if (!bus.req_i[owner_q]) begin
                    // Owner went quiet: give up the lock, costing one idle cycle.
                    state_d = ARB_IDLE;
                    ptr_d   = ptr_inc(owner_q);
                    cnt_d   = '0;
                end else if (!bus.fifo_full_i) begin
                    gnt[owner_q] = 1'b1;
                    if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        state_d = ARB_IDLE;
                        ptr_d   = ptr_inc(owner_q);
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy_o = (state_q == ARB_BURST);
`else
    // Without burst lock MAX_BURST has no effect; busy stays low.
    localparam bit LOCK_EN = 1'b0 && (MAX_BURST >= 1);

    always_comb begin
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt     = '0;
        if (pick_vld && !bus.fifo_full_i) begin
            gnt     = pick_onehot;
            owner_d = pick_idx;
            ptr_d   = ptr_inc(pick_idx);
        end
    end

    assign bus.busy_o = LOCK_EN;
`endif

    always_comb begin
        ovf_d = ovf_q | bus.fifo_wr_error_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q   <= '0;
            owner_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            ovf_q   <= ovf_d;
        end
    end

    // Grants are combinational, so reset must also mask them directly.
    always_comb begin
        gnt_vis = gnt & {N_REQ{rst_ni}};
        bus.fifo_wr_data_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_vis[i]) begin
                bus.fifo_wr_data_o = bus.fifo_wr_data_o | bus.data_i[i*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.gnt_o        = gnt_vis;
    assign bus.fifo_wr_en_o = |gnt_vis;
    assign bus.owner_o      = owner_q;
    assign bus.ovf_err_o    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized/directed bench for fifo_wr_arbiter against a queue-free behavioural model.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int MB    = 4;
    localparam int DEPTH = 16;
`ifdef FIFO_ARB_BURST_EN
    localparam bit LOCK = (MB > 1);
`else
    localparam bit LOCK = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    fifo_wr_arbiter #(
        .N_REQ     (N),
        .WIDTH     (W),
        .MAX_BURST (MB)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    int m_ptr, m_owner, m_beats;
    bit m_locked, m_ovf;
    int fq_cnt;
    bit use_fifo;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr    = 0;
        m_owner  = 0;
        m_beats  = 0;
        m_locked = 1'b0;
        m_ovf    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},   32'(bus.gnt_o), 32'd0);
        check({tag, "_wren"},  32'(bus.fifo_wr_en_o), 32'd0);
        check({tag, "_wdat"},  32'(bus.fifo_wr_data_o), 32'd0);
        check({tag, "_owner"}, 32'(bus.owner_o), 32'd0);
        check({tag, "_busy"},  32'(bus.busy_o), 32'd0);
        check({tag, "_ovf"},   32'(bus.ovf_err_o), 32'd0);
    endtask

    // Called right after a rising edge (+1); leaves at the next rising edge (+1).
    task automatic do_reset(input string tag);
        bus.req_i           = '1;
        bus.data_i          = 32'(32'hA5C3_5A3C);
        bus.fifo_full_i     = 1'b0;
        bus.fifo_wr_error_i = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs({tag, "_a"});
        @(posedge clk);
        #1;
        check_reset_outputs({tag, "_b"});
        rst_n = 1'b1;
    endtask

    task automatic cycle(input logic [N-1:0] req, input bit full_in, input bit err, input bit pop);
        bit             full;
        int             win;
        logic [N-1:0]   e_gnt;
        logic [W-1:0]   e_dat;
        logic [N*W-1:0] dat;
        int             e_owner;
        bit             e_busy, e_ovf;

        full = use_fifo ? (fq_cnt == DEPTH) : full_in;
        for (int i = 0; i < N; i++) dat[i*W +: W] = W'($urandom);
        bus.req_i           = req;
        bus.data_i          = dat;
        bus.fifo_full_i     = full;
        bus.fifo_wr_error_i = err;

        e_owner = m_owner;
        e_busy  = m_locked;
        e_ovf   = m_ovf;
        e_gnt   = '0;
        e_dat   = '0;
        win     = -1;
        if (m_locked) begin
            if (!req[m_owner]) begin
                m_locked = 1'b0;
                m_ptr    = (m_owner + 1) % N;
            end else if (!full) begin
                win = m_owner;
                m_beats++;
                if (m_beats == MB) begin
                    m_locked = 1'b0;
                    m_ptr    = (m_owner + 1) % N;
                end
            end
        end else if (!full) begin
            for (int k = 0; k < N; k++) begin
                if (win < 0 && req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
            if (win >= 0) begin
                m_owner = win;
                if (LOCK) begin
                    m_locked = 1'b1;
                    m_beats  = 1;
                end else begin
                    m_ptr = (win + 1) % N;
                end
            end
        end
        if (win >= 0) begin
            e_gnt[win] = 1'b1;
            e_dat      = dat[win*W +: W];
        end
        m_ovf = m_ovf | err;

        #2;
        check("gnt",   32'(bus.gnt_o), 32'(e_gnt));
        check("wren",  32'(bus.fifo_wr_en_o), 32'(win >= 0));
        check("wdat",  32'(bus.fifo_wr_data_o), 32'(e_dat));
        check("owner", 32'(bus.owner_o), 32'(e_owner));
        check("busy",  32'(bus.busy_o), 32'(e_busy));
        check("ovf",   32'(bus.ovf_err_o), 32'(e_ovf));

        if (use_fifo) begin
            if (win >= 0) fq_cnt++;
            if (pop && fq_cnt > 0) fq_cnt--;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        use_fifo = 1'b0;
        fq_cnt   = 0;
        do_reset("rst0");

        // Fairness with everyone requesting.
        repeat (12) cycle(4'b1111, 1'b0, 1'b0, 1'b0);

        // Two sparse requesters, then requester 0 drops out early.
        repeat (12) cycle(4'b0101, 1'b0, 1'b0, 1'b0);
        do_reset("rst1");
        repeat (2) cycle(4'b0101, 1'b0, 1'b0, 1'b0);
        repeat (4) cycle(4'b0100, 1'b0, 1'b0, 1'b0);

        // Random traffic with random stalls.
        repeat (300) cycle(N'($urandom_range(0, (1 << N) - 1)), ($urandom_range(0, 3) == 0), 1'b0, 1'b0);

        // Fill the FIFO from requester 1 and check grants stop at full.
        do_reset("rst2");
        use_fifo = 1'b1;
        fq_cnt   = 0;
        repeat (22) cycle(4'b0010, 1'b0, 1'b0, 1'b0);
        check("fifo_level_full", 32'(fq_cnt), 32'(DEPTH));
        cycle(4'b0010, 1'b0, 1'b0, 1'b1);
        repeat (3) cycle(4'b0010, 1'b0, 1'b0, 1'b0);
        check("fifo_level_after_pop", 32'(fq_cnt), 32'(DEPTH));
        repeat (40) cycle(N'($urandom_range(0, (1 << N) - 1)), 1'b0, 1'b0, ($urandom_range(0, 1) == 1));
        use_fifo = 1'b0;

        // Sticky overflow flag, cleared only by reset.
        cycle(4'b0000, 1'b0, 1'b1, 1'b0);
        repeat (5) cycle(N'($urandom_range(0, (1 << N) - 1)), 1'b0, 1'b0, 1'b0);
        do_reset("rst3");

        // Reset in the middle of a burst, away from the clock edge.
        repeat (2) cycle(4'b1111, 1'b0, 1'b0, 1'b0);
        bus.req_i = 4'b1111;
        rst_n     = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        check_reset_outputs("midrst_hold");
        rst_n = 1'b1;
        repeat (6) cycle(4'b1111, 1'b0, 1'b0, 1'b0);
        repeat (4) cycle(4'b1010, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
